// File: rtl/t03_text_pixel_streamer_if.sv
// Pixel output bus from the text streamer into the display write path.
//
// Handshake: the master raises pix_valid and holds pix_data/pix_x/pix_y
// stable until the slave samples pix_ready high on the same rising edge.
// That edge is the transfer. The slave's pix_ready has no effect while
// pix_valid is low.
interface t03_text_pixel_streamer_if #(
    parameter int COLOR_W = 16,
    parameter int XW      = 7,
    parameter int YW      = 3
);
    logic [COLOR_W-1:0] pix_data;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic               pix_valid;
    logic               pix_ready;

    modport master (
        output pix_data,
        output pix_x,
        output pix_y,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/t03_text_pixel_streamer.sv
// Text line pixel streamer: latches a packed glyph bitmap plus two colours
// on start, then emits one colour pixel per accepted transfer in raster
// order (row 0 left to right, then row 1, ...), followed by a one-cycle
// done pulse.
module t03_text_pixel_streamer #(
    parameter int NUM_CHARS = 12,
    parameter int X_LEN     = 9,
    parameter int Y_LEN     = 8,
    parameter int COLOR_W   = 16
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 start,
    input  logic [NUM_CHARS*X_LEN*Y_LEN-1:0]     characters,
    input  logic [COLOR_W-1:0]                   fg_color,
    input  logic [COLOR_W-1:0]                   bg_color,
    t03_text_pixel_streamer_if.master            pix,
    output logic                                 busy,
    output logic                                 done,
    output logic [1:0]                           dbg_state
);
    localparam int LINE_W = NUM_CHARS * X_LEN;
    localparam int TOTAL  = LINE_W * Y_LEN;
    localparam int XW     = $clog2(LINE_W);
    localparam int YW     = $clog2(Y_LEN);

    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]         state;
    logic [TOTAL-1:0]   bitmap;   // shifted left per transfer; MSB is the current pixel
    logic [COLOR_W-1:0] fg_q;
    logic [COLOR_W-1:0] bg_q;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic               streaming;

    assign streaming = (state == S_STREAM);

    // Sequencer: latch on start, advance raster position on each transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= S_IDLE;
            bitmap <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bitmap <= characters;
                        fg_q   <= fg_color;
                        bg_q   <= bg_color;
                        x      <= '0;
                        y      <= '0;
                        state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pix.pix_ready) begin
                        bitmap <= bitmap << 1;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                // Park counters at origin rather than wrap past the last row.
                                y     <= '0;
                                state <= S_DONE;
                            end else begin
                                y <= y + YW'(1);
                            end
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode; colour is forced to zero outside the streaming window.
    always_comb begin
        pix.pix_valid = streaming;
        pix.pix_data  = streaming ? (bitmap[TOTAL-1] ? fg_q : bg_q) : '0;
        pix.pix_x     = x;
        pix.pix_y     = y;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        dbg_state     = state;
    end
endmodule

// File: tb/tb_t03_text_pixel_streamer.sv
// Bench for the text pixel streamer: expected pixels are queued per line
// from a bit-index model, a negedge monitor pops and compares accepted
// pixels, and directed checks cover timing, backpressure and reset abort.
module tb_t03_text_pixel_streamer;
    localparam int NUM_CHARS = 12;
    localparam int X_LEN     = 9;
    localparam int Y_LEN     = 8;
    localparam int COLOR_W   = 16;
    localparam int LINE_W    = NUM_CHARS * X_LEN;
    localparam int TOTAL     = LINE_W * Y_LEN;
    localparam int XW        = $clog2(LINE_W);
    localparam int YW        = $clog2(Y_LEN);
    localparam int EW        = COLOR_W + XW + YW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic nrst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic               start;
    logic [TOTAL-1:0]   characters;
    logic [COLOR_W-1:0] fg_color;
    logic [COLOR_W-1:0] bg_color;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;

    t03_text_pixel_streamer_if #(.COLOR_W(COLOR_W), .XW(XW), .YW(YW)) pix ();

    t03_text_pixel_streamer #(
        .NUM_CHARS(NUM_CHARS), .X_LEN(X_LEN), .Y_LEN(Y_LEN), .COLOR_W(COLOR_W)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .characters (characters),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .pix        (pix),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]      exp_q[$];
    logic [COLOR_W-1:0] acc_log[$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: ready held high, 1: pseudo-random ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected raster stream built from the bit-index formula.
    task automatic push_line(input logic [TOTAL-1:0] c, input logic [COLOR_W-1:0] f,
                             input logic [COLOR_W-1:0] b);
        for (int yy = 0; yy < Y_LEN; yy++) begin
            for (int xx = 0; xx < LINE_W; xx++) begin
                logic [COLOR_W-1:0] col;
                col = c[TOTAL-1-(yy*LINE_W+xx)] ? f : b;
                exp_q.push_back({col, XW'(xx), YW'(yy)});
            end
        end
    endtask

    // ---------------- ready driver ----------------
    initial pix.pix_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        pix.pix_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] held;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && pix.pix_valid)
                check("stall_hold", {pix.pix_data, pix.pix_x, pix.pix_y}, held);
            if (pix.pix_valid && pix.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", pix.pix_valid, 1'b0);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("pixel", {pix.pix_data, pix.pix_x, pix.pix_y}, e);
                end
                acc_log.push_back(pix.pix_data);
            end
            prev_stall = pix.pix_valid && !pix.pix_ready;
            held       = {pix.pix_data, pix.pix_x, pix.pix_y};
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one line and waits for done; disturb pulses start and rewrites
    // the inputs mid-stream.
    task automatic run_line(input logic [TOTAL-1:0] c, input logic [COLOR_W-1:0] f,
                            input logic [COLOR_W-1:0] b, input bit disturb);
        int n;
        bit seen;
        @(negedge clk);
        acc_log.delete();
        characters = c;
        fg_color   = f;
        bg_color   = b;
        start      = 1'b1;
        push_line(c, f, b);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (disturb && n == 20) begin
                start      = 1'b1;
                characters = ~c;
                fg_color   = ~f;
                bg_color   = ~b;
            end
            if (disturb && n == 21) start = 1'b0;
            if (n == 1 || n == 400 || done) check("busy_high", busy, 1'b1);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        if (ready_mode == 0) check("line_cycles", n, TOTAL + 1);
        check("queue_empty", exp_q.size(), 0);
        check("accepted_count", acc_log.size(), TOTAL);
        @(negedge clk);
        check("busy_after", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("valid_after", pix.pix_valid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, pix.pix_valid, 1'b0);
        check({tag, "_data"},  pix.pix_data, '0);
        check({tag, "_x"},     pix.pix_x, '0);
        check({tag, "_y"},     pix.pix_y, '0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_state"}, dbg_state, 2'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [TOTAL-1:0] pat;
    initial begin
        nrst       = 1'b0;
        start      = 1'b0;
        characters = '0;
        fg_color   = '0;
        bg_color   = '0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // All-zero glyphs: every pixel is background.
        ready_mode = 0;
        run_line('0, 16'hFFFF, 16'h0000, 1'b0);

        // Only MSB set: (0,0) foreground, rest background.
        pat = '0;
        pat[TOTAL-1] = 1'b1;
        run_line(pat, 16'hF800, 16'h001F, 1'b0);
        check("msb_first_fg", acc_log[0], 16'hF800);
        check("msb_second_bg", acc_log[1], 16'h001F);
        check("msb_last_bg", acc_log[TOTAL-1], 16'h001F);

        // Only LSB set: (107,7) foreground.
        pat = '0;
        pat[0] = 1'b1;
        run_line(pat, 16'h07E0, 16'h1234, 1'b0);
        check("lsb_last_fg", acc_log[TOTAL-1], 16'h07E0);
        check("lsb_first_bg", acc_log[0], 16'h1234);

        // Glyph 'A' row 0 in character 0.
        pat = '0;
        pat[TOTAL-1 -: 9] = 9'b001110000;
        run_line(pat, 16'hAAAA, 16'h5555, 1'b0);
        check("a_x0", acc_log[0], 16'h5555);
        check("a_x1", acc_log[1], 16'h5555);
        check("a_x2", acc_log[2], 16'hAAAA);
        check("a_x3", acc_log[3], 16'hAAAA);
        check("a_x4", acc_log[4], 16'hAAAA);
        check("a_x5", acc_log[5], 16'h5555);
        check("a_x8", acc_log[8], 16'h5555);
        check("a_x9", acc_log[9], 16'h5555);

        // Mixed pattern under random backpressure.
        for (int i = 0; i < TOTAL; i++) pat[i] = ((i % 3) == 0) ^ ((i % 7) == 0);
        ready_mode = 1;
        run_line(pat, 16'hC0DE, 16'h0F0F, 1'b0);

        // Same pattern, ready high, with mid-stream start pulse and input change.
        ready_mode = 0;
        run_line(pat, 16'hBEEF, 16'h4321, 1'b1);

        // Reset abort at pixel (50,3).
        begin
            int n;
            @(negedge clk);
            characters = ~pat;
            fg_color   = 16'h1111;
            bg_color   = 16'h2222;
            start      = 1'b1;
            push_line(~pat, 16'h1111, 16'h2222);
            @(posedge clk);
            #1 start = 1'b0;
            n = 0;
            while (!(pix.pix_valid && pix.pix_x == XW'(50) && pix.pix_y == YW'(3)) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("reached_50_3", n < 2000, 1'b1);
            #2 nrst = 1'b0;
            #1;
            check_idle_outputs("abort");
            exp_q.delete();
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", done, 1'b0);
            end
            nrst = 1'b1;
            @(negedge clk);
            check_idle_outputs("post_abort");
        end
        run_line(pat, 16'h7777, 16'h8888, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
